fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 109 ++++++++++
 tb/tb_fetch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/RUN/DRAIN sequencer feeding a small instruction buffer from a combinational ROM.
// Build option FETCH_PREFETCH_EN: 2-entry buffer with same-cycle pop+push; otherwise a 1-entry buffer.
module fetch_ctrl #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter logic [AW-1:0] START_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          busy
);

    // Consumer handshake: an entry leaves the buffer on a cycle where
    // instr_valid && instr_ready; instr/instr_pc hold while valid && !ready.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_next;
    logic [AW-1:0] fetch_pc, fetch_pc_next;
    logic [1:0]    count, count_next;
    logic [1:0]    wr_pos;
    logic          flush, pop, push, can_push;
    logic [DW-1:0] buf_data [2];
    logic [AW-1:0] buf_pc   [2];

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        flush         = 1'b0;
        push          = 1'b0;
        pop           = instr_valid && instr_ready && !(state == RUN && redirect);
`ifdef FETCH_PREFETCH_EN
        can_push      = (count != 2'd2) || pop;
`else
        can_push      = (count == 2'd0);
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = RUN;
                    fetch_pc_next = START_ADDR;
                end
            end
            RUN: begin
                if (redirect) begin
                    flush         = 1'b1;
                    fetch_pc_next = redirect_addr;
                end else begin
                    push = can_push;
                    if (can_push) fetch_pc_next = fetch_pc + 1'b1;
                    if (stop) state_next = DRAIN;
                end
            end
            DRAIN: ;
            default: state_next = IDLE;
        endcase
        count_next = flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
        // Leave DRAIN on the same edge as the final pop so busy drops right after it.
        if (state == DRAIN && count_next == 2'd0) state_next = IDLE;
        wr_pos = count - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= START_ADDR;
            count    <= 2'd0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            count    <= count_next;
        end
    end

    // Shift-to-head buffer: a pop moves entry 1 down; a push lands after the surviving entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            if (pop) begin
                buf_data[0] <= buf_data[1];
                buf_pc[0]   <= buf_pc[1];
            end
            if (push) begin
                buf_data[wr_pos[0]] <= rom_data;
                buf_pc[wr_pos[0]]   <= fetch_pc;
            end
        end
    end

    assign rom_addr    = fetch_pc;
    assign instr       = buf_data[0];
    assign instr_pc    = buf_pc[0];
    assign instr_valid = (count != 2'd0);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized start/stop/redirect/ready/reset traffic.
module tb_fetch_ctrl;
    localparam int AW = 8;
    localparam int DW = 16;
`ifdef FETCH_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start, stop, redirect, instr_ready;
    logic [AW-1:0] redirect_addr, rom_addr, instr_pc;
    logic [DW-1:0] rom_data, instr;
    logic          instr_valid, busy;

    logic          w_start, w_valid, w_busy;
    logic [AW-1:0] w_rom_addr, w_pc;
    logic [DW-1:0] w_rom_data, w_instr;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state: mode 0=idle 1=run 2=drain, queue of buffered pcs.
    int            m_mode;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] w_seen[$];

    fetch_ctrl #(.AW(AW), .DW(DW), .START_ADDR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .redirect(redirect),
        .redirect_addr(redirect_addr), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .busy(busy)
    );

    fetch_ctrl #(.AW(AW), .DW(DW), .START_ADDR(8'hFE)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(w_start), .stop(1'b0), .redirect(1'b0),
        .redirect_addr(8'h00), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
        .instr(w_instr), .instr_pc(w_pc), .instr_valid(w_valid),
        .instr_ready(1'b1), .busy(w_busy)
    );

    assign rom_data   = {rom_addr, ~rom_addr};
    assign w_rom_data = {w_rom_addr, ~w_rom_addr};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "watchdog");
    end

    // Reference model, updated on each active edge from the inputs the DUT samples.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0;
            m_pc   = 8'h00;
            exp_q.delete();
        end else begin
            bit pop_ok, room;
            pop_ok = (exp_q.size() > 0) && instr_ready && !(m_mode == 1 && redirect);
            if (m_mode == 0) begin
                if (start) begin
                    m_mode = 1;
                    m_pc   = 8'h00;
                end
            end else if (m_mode == 1) begin
                if (redirect) begin
                    exp_q.delete();
                    m_pc = redirect_addr;
                end else begin
                    room = PREFETCH ? (exp_q.size() < 2 || pop_ok) : (exp_q.size() == 0);
                    if (pop_ok) void'(exp_q.pop_front());
                    if (room) begin
                        exp_q.push_back(m_pc);
                        m_pc = m_pc + 8'd1;
                    end
                    if (stop) m_mode = 2;
                end
            end else begin
                if (pop_ok) void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_mode = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit            e_valid, bad;
            logic [AW-1:0] e_pc;
            e_valid = (exp_q.size() > 0);
            e_pc    = e_valid ? exp_q[0] : 8'h00;
            bad = (rom_addr !== m_pc) || (busy !== (m_mode != 0)) || (instr_valid !== e_valid)
                  || (e_valid && ((instr_pc !== e_pc) || (instr !== {e_pc, ~e_pc})));
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t rom_addr=%h exp %h busy=%b exp %b valid=%b exp %b pc=%h exp %h instr=%h exp %h",
                         $time, rom_addr, m_pc, busy, (m_mode != 0), instr_valid, e_valid,
                         instr_pc, e_pc, instr, {e_pc, ~e_pc});
            end
        end
    end

    // Wrap-instance monitor: records delivered pcs and checks the word matches the ROM.
    always @(negedge clk) begin
        if (chk_en && rst_n && w_valid && w_seen.size() < 8) begin
            w_seen.push_back(w_pc);
            n_tests++;
            if (w_instr !== {w_pc, ~w_pc}) begin
                n_fail++;
                $display("FAIL wrap_word pc=%h got %h exp %h", w_pc, w_instr, {w_pc, ~w_pc});
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        bit found, ok;
        start = 0; stop = 0; redirect = 0; redirect_addr = 0; instr_ready = 0; w_start = 0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_rom_addr", rom_addr, 8'h00);
        check("reset_instr", instr, 16'h0000);
        check("reset_instr_pc", instr_pc, 8'h00);
        check("reset_valid", instr_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_wrap_rom_addr", w_rom_addr, 8'hFE);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        // Start and first fetch latency.
        start = 1; w_start = 1; instr_ready = 0;
        step();
        start = 0; w_start = 0;
        check("start_rom_addr", rom_addr, 8'h00);
        check("start_busy", busy, 1'b1);
        check("start_valid_early", instr_valid, 1'b0);
        step();
        check("first_valid", instr_valid, 1'b1);
        check("first_instr", instr, 16'h00FF);
        check("first_pc", instr_pc, 8'h00);
        repeat (4) step();
        check("stall_instr", instr, 16'h00FF);
        check("stall_rom_addr", rom_addr, PREFETCH ? 8'h02 : 8'h01);
        instr_ready = 1;
        step();
        if (PREFETCH) check("release_1", {instr_valid, instr}, {1'b1, 16'h01FE});
        else          check("release_1", instr_valid, 1'b0);
        step();
        if (PREFETCH) check("release_2", {instr_valid, instr}, {1'b1, 16'h02FD});
        else          check("release_2", {instr_valid, instr}, {1'b1, 16'h01FE});

        // Redirect while pc 3 is at the head.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid && instr_pc == 8'h03) found = 1;
            else step();
        end
        check("pc3_reached", found, 1'b1);
        redirect = 1; redirect_addr = 8'h40;
        step();
        redirect = 0;
        check("redir_valid_low", instr_valid, 1'b0);
        check("redir_rom_addr", rom_addr, 8'h40);
        step();
        check("redir_instr", {instr_valid, instr_pc, instr}, {1'b1, 8'h40, 16'h40BF});
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (instr_valid && (instr_pc < 8'h40 || instr_pc >= 8'h50)) ok = 0;
        end
        check("no_stale_pcs", ok, 1'b1);

        check("wrap_count", (w_seen.size() >= 4), 1'b1);
        if (w_seen.size() >= 4)
            check("wrap_order", {w_seen[0], w_seen[1], w_seen[2], w_seen[3]}, 32'hFEFF0001);

        // Stop with the buffer full, then drain.
        instr_ready = 0;
        repeat (3) step();
        stop = 1;
        step();
        stop = 0;
        check("stop_busy", busy, 1'b1);
        check("stop_valid", instr_valid, 1'b1);
        instr_ready = 1;
        step();
        if (PREFETCH) check("drain_1", {busy, instr_valid}, 2'b11);
        else          check("drain_1", {busy, instr_valid}, 2'b00);
        if (PREFETCH) begin
            step();
            check("drain_2", {busy, instr_valid}, 2'b00);
        end
        redirect = 1; redirect_addr = 8'h10;
        step();
        redirect = 0;
        check("idle_redirect_ignored", {busy, instr_valid, (rom_addr == 8'h10)}, 3'b000);

        // Reset while running with a full buffer.
        start = 1; instr_ready = 0;
        step();
        start = 0;
        repeat (3) step();
        check("pre_reset_full", {busy, instr_valid}, 2'b11);
        rst_n = 0;
        #1;
        check("async_reset_valid", instr_valid, 1'b0);
        check("async_reset_rom_addr", rom_addr, 8'h00);
        check("async_reset_busy", busy, 1'b0);
        step();
        rst_n = 1;
        instr_ready = 1;
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (instr_valid || busy) ok = 0;
        end
        check("no_instr_after_reset", ok, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            start         = ($urandom_range(0, 7) == 0);
            stop          = ($urandom_range(0, 39) == 0);
            redirect      = ($urandom_range(0, 29) == 0);
            redirect_addr = 8'($urandom_range(0, 255));
            instr_ready   = ($urandom_range(0, 3) != 0);
            rst_n         = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_n = 1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
